// File: rtl/intra_pkg.sv
// Shared types and constants for the intra 16x16 luma mode-decision block.
package intra_pkg;

    localparam int MB_DIM = 16;
    localparam int SAD_W  = 16;
    localparam int NPIX   = MB_DIM * MB_DIM;

    localparam logic [7:0] DC_DEFAULT = 8'd128;

    typedef enum logic [1:0] {
        VERT = 2'd0,
        HORZ = 2'd1,
        DC   = 2'd2
    } mode_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PREP  = 2'd1,
        EVAL  = 2'd2,
        FINAL = 2'd3
    } state_e;

    function automatic logic [7:0] abs_diff(input logic [7:0] a, input logic [7:0] b);
        return (a > b) ? (a - b) : (b - a);
    endfunction

endpackage

// File: rtl/intra16x16_row_sad.sv
// Combinational sum of absolute differences over one 16-pixel row.
module intra16x16_row_sad
    import intra_pkg::*;
(
    input  logic [7:0]  src [MB_DIM],
    input  logic [7:0]  prd [MB_DIM],
    output logic [11:0] sad
);

    always_comb begin
        sad = '0;
        for (int unsigned i = 0; i < MB_DIM; i++) begin
            sad = sad + {4'd0, abs_diff(src[4'(i)], prd[4'(i)])};
        end
    end

endmodule

// File: rtl/intra16x16_mode_decision.sv
// Intra 16x16 luma prediction: scores vertical/horizontal/DC by SAD one row per
// cycle and presents the best mode, its SAD and its full prediction.
module intra16x16_mode_decision
    import intra_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [7:0]       mb [NPIX],
    input  logic [7:0]       toppixels [MB_DIM],
    input  logic [7:0]       leftpixels [MB_DIM],
    input  logic             top_avail,
    input  logic             left_avail,
    output logic             busy,
    output logic             done,
    output logic [1:0]       best_mode,
    output logic [SAD_W-1:0] best_sad,
    output logic [7:0]       pred [NPIX]
);

    state_e           state_q, state_d;
    logic [7:0]       mb_q [NPIX];
    logic [7:0]       mb_d [NPIX];
    logic [7:0]       top_q [MB_DIM];
    logic [7:0]       top_d [MB_DIM];
    logic [7:0]       left_q [MB_DIM];
    logic [7:0]       left_d [MB_DIM];
    logic             top_avail_q, top_avail_d;
    logic             left_avail_q, left_avail_d;
    logic [7:0]       dc_q, dc_d;
    mode_e            cand_q [4];
    mode_e            cand_d [4];
    logic [1:0]       last_idx_q, last_idx_d;
    logic [1:0]       cand_idx_q, cand_idx_d;
    logic [3:0]       row_q, row_d;
    logic [SAD_W-1:0] acc_q, acc_d;
    logic [SAD_W-1:0] run_sad_q, run_sad_d;
    mode_e            run_mode_q, run_mode_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    mode_e            best_mode_q, best_mode_d;
    logic [SAD_W-1:0] best_sad_q, best_sad_d;
    logic [7:0]       pred_q [NPIX];
    logic [7:0]       pred_d [NPIX];

    logic [11:0] sum_t, sum_l, rnd_t, rnd_l;
    logic [12:0] sum_tl;
    logic [7:0]  dc_val;

    always_comb begin
        sum_t = '0;
        sum_l = '0;
        for (int unsigned i = 0; i < MB_DIM; i++) begin
            sum_t = sum_t + {4'd0, top_q[4'(i)]};
            sum_l = sum_l + {4'd0, left_q[4'(i)]};
        end
        // Rounding constant is added before the shift; all sums fit without overflow.
        sum_tl = {1'b0, sum_t} + {1'b0, sum_l} + 13'd16;
        rnd_t  = sum_t + 12'd8;
        rnd_l  = sum_l + 12'd8;
        if (top_avail_q && left_avail_q) dc_val = sum_tl[12:5];
        else if (top_avail_q)            dc_val = rnd_t[11:4];
        else if (left_avail_q)           dc_val = rnd_l[11:4];
        else                             dc_val = DC_DEFAULT;
    end

    mode_e            cur_mode;
    logic [7:0]       src_row [MB_DIM];
    logic [7:0]       prd_row [MB_DIM];
    logic [11:0]      row_sad;
    logic [SAD_W-1:0] cand_total;

    always_comb begin
        cur_mode = cand_q[cand_idx_q];
        for (int unsigned c = 0; c < MB_DIM; c++) begin
            src_row[4'(c)] = mb_q[{row_q, 4'(c)}];
            case (cur_mode)
                VERT:    prd_row[4'(c)] = top_q[4'(c)];
                HORZ:    prd_row[4'(c)] = left_q[row_q];
                default: prd_row[4'(c)] = dc_q;
            endcase
        end
    end

    intra16x16_row_sad u_row_sad (
        .src (src_row),
        .prd (prd_row),
        .sad (row_sad)
    );

    assign cand_total = acc_q + SAD_W'(row_sad);

    always_comb begin
        state_d      = state_q;
        mb_d         = mb_q;
        top_d        = top_q;
        left_d       = left_q;
        top_avail_d  = top_avail_q;
        left_avail_d = left_avail_q;
        dc_d         = dc_q;
        cand_d       = cand_q;
        last_idx_d   = last_idx_q;
        cand_idx_d   = cand_idx_q;
        row_d        = row_q;
        acc_d        = acc_q;
        run_sad_d    = run_sad_q;
        run_mode_d   = run_mode_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        best_mode_d  = best_mode_q;
        best_sad_d   = best_sad_q;
        pred_d       = pred_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    mb_d         = mb;
                    top_d        = toppixels;
                    left_d       = leftpixels;
                    top_avail_d  = top_avail;
                    left_avail_d = left_avail;
                    busy_d       = 1'b1;
                    state_d      = PREP;
                end
            end
            PREP: begin
                dc_d       = dc_val;
                cand_idx_d = '0;
                row_d      = '0;
                acc_d      = '0;
                case ({top_avail_q, left_avail_q})
                    2'b11: begin cand_d = '{VERT, HORZ, DC, DC}; last_idx_d = 2'd2; end
                    2'b10: begin cand_d = '{VERT, DC, DC, DC};   last_idx_d = 2'd1; end
                    2'b01: begin cand_d = '{HORZ, DC, DC, DC};   last_idx_d = 2'd1; end
                    default: begin cand_d = '{DC, DC, DC, DC};   last_idx_d = 2'd0; end
                endcase
                state_d = EVAL;
            end
            EVAL: begin
                row_d = row_q + 4'd1;
                acc_d = cand_total;
                if (row_q == 4'd15) begin
                    acc_d = '0;
                    // Strictly-smaller replacement keeps the earlier mode on ties.
                    if (cand_idx_q == 2'd0 || cand_total < run_sad_q) begin
                        run_sad_d  = cand_total;
                        run_mode_d = cur_mode;
                    end
                    if (cand_idx_q == last_idx_q) begin
                        state_d     = FINAL;
                        done_d      = 1'b1;
                        best_mode_d = run_mode_d;
                        best_sad_d  = run_sad_d;
                        for (int unsigned r = 0; r < MB_DIM; r++) begin
                            for (int unsigned c = 0; c < MB_DIM; c++) begin
                                case (run_mode_d)
                                    VERT:    pred_d[{4'(r), 4'(c)}] = top_q[4'(c)];
                                    HORZ:    pred_d[{4'(r), 4'(c)}] = left_q[4'(r)];
                                    default: pred_d[{4'(r), 4'(c)}] = dc_q;
                                endcase
                            end
                        end
                    end else begin
                        cand_idx_d = cand_idx_q + 2'd1;
                    end
                end
            end
            FINAL: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            mb_q         <= '{default: '0};
            top_q        <= '{default: '0};
            left_q       <= '{default: '0};
            top_avail_q  <= 1'b0;
            left_avail_q <= 1'b0;
            dc_q         <= '0;
            cand_q       <= '{default: VERT};
            last_idx_q   <= '0;
            cand_idx_q   <= '0;
            row_q        <= '0;
            acc_q        <= '0;
            run_sad_q    <= '0;
            run_mode_q   <= VERT;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            best_mode_q  <= VERT;
            best_sad_q   <= '0;
            pred_q       <= '{default: '0};
        end else begin
            state_q      <= state_d;
            mb_q         <= mb_d;
            top_q        <= top_d;
            left_q       <= left_d;
            top_avail_q  <= top_avail_d;
            left_avail_q <= left_avail_d;
            dc_q         <= dc_d;
            cand_q       <= cand_d;
            last_idx_q   <= last_idx_d;
            cand_idx_q   <= cand_idx_d;
            row_q        <= row_d;
            acc_q        <= acc_d;
            run_sad_q    <= run_sad_d;
            run_mode_q   <= run_mode_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            best_mode_q  <= best_mode_d;
            best_sad_q   <= best_sad_d;
            pred_q       <= pred_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign best_mode = best_mode_q;
    assign best_sad  = best_sad_q;
    assign pred      = pred_q;

endmodule

// File: tb/tb_intra16x16_mode_decision.sv
// Scoreboard bench for intra16x16_mode_decision: a reference model pushes the
// expected mode/SAD/prediction/latency at start, and results are popped at done.
module tb_intra16x16_mode_decision;
    import intra_pkg::*;

    logic        clk = 1'b0;
    logic        reset, start, top_avail, left_avail;
    logic [7:0]  mb [256];
    logic [7:0]  toppixels [16];
    logic [7:0]  leftpixels [16];
    logic        busy, done;
    logic [1:0]  best_mode;
    logic [15:0] best_sad;
    logic [7:0]  pred [256];

    int n_checks = 0;
    int n_fail   = 0;

    logic [1:0]    q_mode [$];
    logic [15:0]   q_sad  [$];
    logic [2047:0] q_pred [$];
    int            q_lat  [$];

    always #5 clk = ~clk;

    intra16x16_mode_decision dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .mb         (mb),
        .toppixels  (toppixels),
        .leftpixels (leftpixels),
        .top_avail  (top_avail),
        .left_avail (left_avail),
        .busy       (busy),
        .done       (done),
        .best_mode  (best_mode),
        .best_sad   (best_sad),
        .pred       (pred)
    );

    task automatic model(output logic [1:0] m, output logic [15:0] s,
                         output logic [2047:0] p, output int lat);
        int st, sl, dcv, n, best, d;
        int sad [3];
        bit av [3];
        logic [7:0] pv;
        bit first;
        st = 0; sl = 0;
        for (int i = 0; i < 16; i++) begin
            st += int'(toppixels[i]);
            sl += int'(leftpixels[i]);
        end
        if (top_avail && left_avail) dcv = (st + sl + 16) / 32;
        else if (top_avail)          dcv = (st + 8) / 16;
        else if (left_avail)         dcv = (sl + 8) / 16;
        else                         dcv = 128;
        av[0] = top_avail; av[1] = left_avail; av[2] = 1'b1;
        for (int md = 0; md < 3; md++) begin
            sad[md] = 0;
            for (int r = 0; r < 16; r++) begin
                for (int c = 0; c < 16; c++) begin
                    if (md == 0)      pv = toppixels[c];
                    else if (md == 1) pv = leftpixels[r];
                    else              pv = dcv[7:0];
                    d = int'(mb[r*16+c]) - int'(pv);
                    sad[md] += (d < 0) ? -d : d;
                end
            end
        end
        first = 1'b1; best = 0; m = 2'd2; n = 0;
        for (int md = 0; md < 3; md++) begin
            if (av[md]) begin
                n++;
                if (first || sad[md] < best) begin
                    best = sad[md];
                    m = 2'(md);
                end
                first = 1'b0;
            end
        end
        s = 16'(best);
        lat = 16 * n + 2;
        for (int r = 0; r < 16; r++) begin
            for (int c = 0; c < 16; c++) begin
                if (m == 2'd0)      pv = toppixels[c];
                else if (m == 2'd1) pv = leftpixels[r];
                else                pv = dcv[7:0];
                p[8*(r*16+c) +: 8] = pv;
            end
        end
    endtask

    // Caller is at a negedge; start is sampled on the following posedge (cycle 0).
    task automatic launch(input bit push);
        logic [1:0] m; logic [15:0] s; logic [2047:0] p; int lat;
        if (push) begin
            model(m, s, p, lat);
            q_mode.push_back(m); q_sad.push_back(s); q_pred.push_back(p); q_lat.push_back(lat);
        end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic set_uniform(input int mbv, input int tv, input int lv, input bit ta, input bit la);
        for (int i = 0; i < 256; i++) mb[i] = 8'(mbv);
        for (int i = 0; i < 16; i++) begin
            toppixels[i]  = 8'(tv);
            leftpixels[i] = 8'(lv);
        end
        top_avail = ta; left_avail = la;
    endtask

    task automatic set_random();
        for (int i = 0; i < 256; i++) mb[i] = 8'($urandom_range(0, 255));
        for (int i = 0; i < 16; i++) begin
            toppixels[i]  = 8'($urandom_range(0, 255));
            leftpixels[i] = 8'($urandom_range(0, 255));
        end
        top_avail  = 1'($urandom_range(0, 1));
        left_avail = 1'($urandom_range(0, 1));
    endtask

    // Scoreboard consumer: waits (bounded) for done and compares against the queue head.
    task automatic collect(input int cyc0, input string tag);
        int cyc;
        bit busy_ok;
        logic [1:0] em; logic [15:0] es; logic [2047:0] ep, act; int el;
        cyc = cyc0; busy_ok = 1'b1;
        while (done !== 1'b1 && cyc < 200) begin
            if (busy !== 1'b1) busy_ok = 1'b0;
            @(negedge clk);
            cyc++;
        end
        n_checks++;
        if (q_mode.size() == 0) begin
            n_fail++;
            $display("FAIL %s scoreboard: queue empty, required one entry", tag);
            return;
        end
        em = q_mode.pop_front(); es = q_sad.pop_front(); ep = q_pred.pop_front(); el = q_lat.pop_front();
        if (done !== 1'b1) begin
            n_fail++;
            $display("FAIL %s done: no done within %0d cycles, required done in cycle %0d", tag, cyc, el);
            return;
        end
        n_checks++;
        if (cyc !== el) begin
            n_fail++;
            $display("FAIL %s latency: done in cycle %0d, required %0d", tag, cyc, el);
        end
        n_checks++;
        if (busy_ok !== 1'b1 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL %s busy: busy dropped during run, required high through done", tag);
        end
        n_checks++;
        if (best_mode !== em) begin
            n_fail++;
            $display("FAIL %s best_mode: got %0d, required %0d", tag, best_mode, em);
        end
        n_checks++;
        if (best_sad !== es) begin
            n_fail++;
            $display("FAIL %s best_sad: got %0d, required %0d", tag, best_sad, es);
        end
        for (int i = 0; i < 256; i++) act[8*i +: 8] = pred[i];
        n_checks++;
        if (act !== ep) begin
            n_fail++;
            for (int i = 0; i < 256; i++) begin
                if (act[8*i +: 8] !== ep[8*i +: 8]) begin
                    $display("FAIL %s pred: pred[%0d]=%0d, required %0d", tag, i, act[8*i +: 8], ep[8*i +: 8]);
                    break;
                end
            end
        end
    endtask

    task automatic check_idle_zero(input string tag);
        bit pz;
        pz = 1'b1;
        for (int i = 0; i < 256; i++) if (pred[i] !== 8'd0) pz = 1'b0;
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0 || best_mode !== 2'd0 || best_sad !== 16'd0 || pz !== 1'b1) begin
            n_fail++;
            $display("FAIL %s outputs: busy=%0d done=%0d mode=%0d sad=%0d pred_zero=%0d, required all 0 (pred_zero=1)",
                     tag, busy, done, best_mode, best_sad, pz);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0;
        set_uniform(0, 0, 0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        check_idle_zero("reset");
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_vertical();
        set_uniform(100, 100, 50, 1'b1, 1'b1);
        launch(1'b1);
        collect(1, "vertical");
    endtask

    task automatic test_horizontal();
        for (int r = 0; r < 16; r++) begin
            leftpixels[r] = 8'(10 * r);
            toppixels[r]  = 8'd255;
            for (int c = 0; c < 16; c++) mb[r*16+c] = 8'(10 * r);
        end
        top_avail = 1'b1; left_avail = 1'b1;
        @(negedge clk);
        launch(1'b1);
        collect(1, "horizontal");
    endtask

    task automatic test_dc_none();
        set_uniform(128, 7, 9, 1'b0, 1'b0);
        @(negedge clk);
        launch(1'b1);
        collect(1, "dc_none");
    endtask

    task automatic test_tie();
        set_uniform(20, 10, 77, 1'b1, 1'b0);
        @(negedge clk);
        launch(1'b1);
        collect(1, "tie_top_only");
    endtask

    task automatic test_dc_both();
        set_uniform(32, 0, 64, 1'b1, 1'b1);
        @(negedge clk);
        launch(1'b1);
        collect(1, "dc_both");
    endtask

    task automatic test_ignored_start();
        bit extra;
        set_uniform(100, 100, 50, 1'b1, 1'b1);
        @(negedge clk);
        launch(1'b1);
        repeat (4) @(negedge clk);
        set_random();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        collect(6, "ignored_start");
        extra = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) extra = 1'b1;
        end
        n_checks++;
        if (extra !== 1'b0) begin
            n_fail++;
            $display("FAIL ignored_start second_run: extra activity seen=1, required 0");
        end
    endtask

    task automatic test_reset_midrun();
        bit seen;
        set_uniform(100, 100, 50, 1'b1, 1'b1);
        @(negedge clk);
        launch(1'b0);
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_idle_zero("reset_midrun");
        reset = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (done === 1'b1) seen = 1'b1;
        end
        n_checks++;
        if (seen !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_midrun done: done pulsed=1, required 0");
        end
        set_uniform(32, 0, 64, 1'b1, 1'b1);
        @(negedge clk);
        launch(1'b1);
        collect(1, "after_reset");
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 5; k++) begin
            set_random();
            @(negedge clk);
            if (k > 0) begin
                n_checks++;
                if (done !== 1'b0 || busy !== 1'b0) begin
                    n_fail++;
                    $display("FAIL back_to_back idle_gap: done=%0d busy=%0d, required 0 0", done, busy);
                end
            end
            launch(1'b1);
            collect(1, $sformatf("back_to_back_%0d", k));
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0;
        set_uniform(0, 0, 0, 1'b0, 1'b0);
        test_reset();
        test_vertical();
        test_horizontal();
        test_dc_none();
        test_tie();
        test_dc_both();
        test_ignored_start();
        test_reset_midrun();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
